// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Operation and state encodings for the multiply/divide unit.
// Revision    : 1.0
// ============================================================================
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_if
// Description : Control-unit side handshake and HI/LO bus of the MDU.
// Revision    : 1.0
// ============================================================================
interface mult_div_unit_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    mdu_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       state_out;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo, state_out
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo, state_out
    );
endinterface
`default_nettype wire

// File: rtl/mdu_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter_core
// Description : Shift-add / restoring-divide datapath, one bit per cycle.
// Revision    : 1.0
// ============================================================================
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_step,
    input  wire logic             i_is_div,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_acc_nxt,
    output logic      [WIDTH-1:0] o_mq_nxt,
    output logic                  o_last
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // Multiply: {acc,mq} shifts right with the carry of acc+b entering from the top.
    assign w_sum   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_b} : '0);
    // Divide: partial remainder stays below b, so a WIDTH-bit difference is exact.
    assign w_shift = {r_acc, r_mq[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    assign w_diff  = w_shift[WIDTH-1:0] - r_b;

    always_comb begin
        if (i_is_div) begin
            o_acc_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
            o_mq_nxt  = {r_mq[WIDTH-2:0], w_ge};
        end else begin
            o_acc_nxt = w_sum[WIDTH:1];
            o_mq_nxt  = {w_sum[0], r_mq[WIDTH-1:1]};
        end
    end

    assign o_last = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_mq  <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_acc <= '0;
            r_mq  <= i_a;
            r_b   <= i_b;
            r_cnt <= c_cnt_init;
        end else if (i_step) begin
            r_acc <= o_acc_nxt;
            r_mq  <= o_mq_nxt;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
//               MDU_DIVZERO_EXC_EN: divide by zero keeps HI/LO, flags div_zero.
// Revision    : 1.0
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic       clock,
    input  wire logic       reset,
    mult_div_unit_if.slave  bus
);
    mdu_state_t       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [1:0]         w_op;
    logic               w_idle;
    logic               w_signed;
    logic               w_b_zero;
    logic               w_load;
    logic               w_running;
    logic               w_last;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_mq_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_op      = bus.op;
    assign w_idle    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_running = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign w_signed  = ~w_op[0];
    assign w_b_zero  = (bus.b == '0);
    assign w_load    = w_idle & bus.start & ~(w_op[1] & w_b_zero);
    assign w_mag_a   = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_mag_b   = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    mdu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clock),
        .rst       (reset),
        .i_load    (w_load),
        .i_step    (w_running),
        .i_is_div  (r_state == ST_DIV),
        .i_a       (w_mag_a),
        .i_b       (w_mag_b),
        .o_acc_nxt (w_acc_nxt),
        .o_mq_nxt  (w_mq_nxt),
        .o_last    (w_last)
    );

    // Sign fix-up on the final-iteration values, written as the FSM enters DONE.
    assign w_prod     = {w_acc_nxt, w_mq_nxt};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_res_hi   = (r_state == ST_DIV) ? (r_neg_r ? -w_acc_nxt : w_acc_nxt)
                                            : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo   = (r_state == ST_DIV) ? (r_neg_q ? -w_mq_nxt : w_mq_nxt)
                                            : w_prod_fix[WIDTH-1:0];

`ifdef MDU_DIVZERO_EXC_EN
    logic r_div_zero;
    assign bus.div_zero = r_div_zero;
`else
    assign bus.div_zero = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef MDU_DIVZERO_EXC_EN
            r_div_zero <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MDU_DIVZERO_EXC_EN
            r_div_zero <= 1'b0;
`endif
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.hi_we) r_hi <= bus.wdata;
                    if (bus.lo_we) r_lo <= bus.wdata;
                    if (bus.start) begin
                        r_neg_q <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg_r <= w_signed & bus.a[WIDTH-1];
                        if (w_op[1] && w_b_zero) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`ifdef MDU_DIVZERO_EXC_EN
                            r_div_zero <= 1'b1;
`else
                            r_hi <= bus.a;
                            r_lo <= '1;
`endif
                        end else begin
                            r_state <= w_op[1] ? ST_DIV : ST_MUL;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.state_out = r_state;
endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit for the multicycle CPU datapath. It generalises the fixed 32-bit multiplier to a WIDTH-bit engine covering MULT, MULTU, DIV and DIVU. It owns the architectural HI/LO registers, including direct MTHI/MTLO writes. The control unit drives it through a start/busy/done handshake and watches state_out.

Parameters:
WIDTH, 32, operand and HI/LO width (≥4, even)
CNT_W, $clog2(WIDTH), iteration counter width (derived; not overridden)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request operation; sampled only when not busy
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  in  WIDTH  operand rs (multiplicand/dividend)
b  in  WIDTH  operand rt (multiplier/divisor)
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in progress
done  out  1  one-cycle pulse; HI/LO hold the result
div_zero  out  1  divide-by-zero flag (see Optional Feature)
hi  out  WIDTH  HI register (product high / remainder)
lo  out  WIDTH  LO register (product low / quotient)
state_out  out  2  FSM state: 0 IDLE, 1 MUL, 2 DIV, 3 DONE

Behaviour:
- Reset: state IDLE; hi=lo=0; busy=done=div_zero=0; counter=0. Reset mid-operation aborts the operation. The result is discarded and hi/lo return to 0.
- Accept: start=1 in IDLE or DONE latches a, b and op on that edge.
  - Signed ops latch magnitudes plus the sign bits.
  - Next state is MUL (op 0x) or DIV (op 1x); counter=WIDTH-1.
- start while in MUL or DIV is ignored. It is not queued.
- MUL: radix-2 shift-add on the magnitudes, one multiplier bit per cycle.
- DIV: restoring division, one quotient bit per cycle.
- Each state runs exactly WIDTH cycles. When counter==0, the next edge moves to DONE and writes hi/lo.
- Latency: done=1 in the (WIDTH+1)th cycle after the accept edge (33 for WIDTH=32). busy=1 throughout MUL and DIV, 0 in IDLE and DONE.
- Sign fix-up, applied on the DONE write:
  - MULT: negate the 2·WIDTH product if sign(a)^sign(b).
  - DIV: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - MIN/-1 gives LO=MIN, HI=0 with no exception.
- Divide by zero (b==0 on a DIV/DIVU accept): next state is DONE directly, latency 1. The result follows Optional Feature.
- DONE always moves to IDLE on the next edge unless a new start is accepted. Back-to-back accept from DONE is legal.
- hi_we/lo_we write wdata in IDLE or DONE. They are ignored while busy.
- Same-edge result write and hi_we/lo_we (entering DONE while the strobe is high): the strobe is busy-gated, so the result wins.
- start together with hi_we in IDLE: both take effect. The write lands now and is later overwritten by the result.
- hi/lo change only on reset, DONE entry or a permitted MTHI/MTLO write.

Optional Feature:
Macro MDU_DIVZERO_EXC_EN.
- Defined: divide by zero leaves hi/lo unchanged and pulses div_zero=1 together with done. The control unit uses this as an exception cause.
- Undefined: divide by zero writes HI=a and LO=all ones. div_zero is tied to 0.

Decomposition:
- Package mdu_pkg holds:
  - mdu_op_t enum (MULT, MULTU, DIV, DIVU)
  - mdu_state_t enum (IDLE, MUL, DIV, DONE), 2 bits, values as listed under state_out
- One sub-module, mdu_iter_core, holds:
  - the accumulator/remainder and multiplier/quotient shift registers
  - the counter
  - the per-cycle add/subtract step
  - a last-iteration flag for the FSM
- The FSM, sign handling and HI/LO registers stay in mult_div_unit.

Test Plan:
- MULT a=FFFFFFFD, b=00000007 → done 33 cycles after the accept edge; HI=FFFFFFFF, LO=FFFFFFEB; busy high for 32 cycles.
- MULTU a=FFFFFFFF, b=FFFFFFFF → HI=FFFFFFFE, LO=00000001.
- DIV a=FFFFFFF9, b=00000002 → LO=FFFFFFFD, HI=FFFFFFFF; DIVU a=7, b=2 → LO=3, HI=1.
- DIV a=80000000, b=FFFFFFFF → LO=80000000, HI=00000000; div_zero=0.
- DIVU a=00001234, b=0 with prior HI=LO=5 → done on the cycle after accept:
  - macro undefined: HI=00001234, LO=FFFFFFFF
  - macro defined: div_zero=1, HI=LO=5
- Control and reset:
  - start pulsed at cycle 5 of a MULT is ignored.
  - hi_we while busy is ignored.
  - reset at cycle 10 of a MULT → next cycle busy=0, state_out=0, hi=lo=0.
  - hi_we in IDLE with wdata=ABCD0000 → HI=ABCD0000.
